// File: rtl/qlearn_pkg.sv
// Shared widths, encodings and helpers for the maze-solver Q-learning blocks.
package qlearn_pkg;
    localparam int STATE_W  = 6;
    localparam int ACTION_W = 2;
    localparam int Q_W      = 16;
    localparam int ADDR_W   = STATE_W + ACTION_W;
    localparam int NUM_ENT  = 1 << ADDR_W;

    typedef enum logic [ACTION_W-1:0] {
        ACT_UP    = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_DOWN  = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    localparam logic [STATE_W-1:0] GOAL_STATE = 6'd25;

    localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_WR
    } upd_state_e;

    // Clamp a 20-bit intermediate back into the Q-value range.
    function automatic logic signed [Q_W-1:0] sat_q(input logic signed [19:0] v);
        if (v > 20'(Q_MAX))      return Q_MAX;
        else if (v < 20'(Q_MIN)) return Q_MIN;
        else                     return v[Q_W-1:0];
    endfunction
endpackage

// File: rtl/q_update_unit_if.sv
// Transition request / result bus plus the greedy-selector query port.
interface q_update_unit_if;
    import qlearn_pkg::*;

    logic                       start;
    logic [STATE_W-1:0]         cur_state;
    logic [ACTION_W-1:0]        action;
    logic [STATE_W-1:0]         next_state;
    logic signed [Q_W-1:0]      reward;
    logic                       terminal;
    logic                       ready;
    logic                       done;
    logic signed [Q_W-1:0]      q_new;
    logic [STATE_W-1:0]         qry_state;
    logic [ACTION_W-1:0]        qry_action;
    logic signed [Q_W-1:0]      qry_q;

    modport master (
        output start, cur_state, action, next_state, reward, terminal, qry_state, qry_action,
        input  ready, done, q_new, qry_q
    );
    modport slave (
        input  start, cur_state, action, next_state, reward, terminal, qry_state, qry_action,
        output ready, done, q_new, qry_q
    );
endinterface

// File: rtl/q_table_ram.sv
// 256-entry Q-table: port A read/write for the update FSM, port B read-only query.
module q_table_ram
    import qlearn_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [Q_W-1:0]    wdata_a_i,
    output logic [Q_W-1:0]    rdata_a_o,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic [Q_W-1:0]    rdata_b_o
);
    logic [Q_W-1:0] mem_q [NUM_ENT];
    logic [Q_W-1:0] rd_a_q, rd_b_q;

    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[addr_a_i] <= wdata_a_i;
    end

    // Port B forwards a same-edge write so the selector never sees a stale value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= mem_q[addr_a_i];
            rd_b_q <= (we_a_i && addr_a_i == addr_b_i) ? wdata_a_i : mem_q[addr_b_i];
        end
    end

    assign rdata_a_o = rd_a_q;
    assign rdata_b_o = rd_b_q;
endmodule

// File: rtl/q_update_unit.sv
// Q-learning update stage: clears the table, then applies one saturating update per request.
module q_update_unit
    import qlearn_pkg::*;
#(
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA       = 230
) (
    input  logic            clk,
    input  logic            rst_n,
    q_update_unit_if.slave  bus
);
    upd_state_e             state_q;
    logic [ADDR_W-1:0]      cnt_q;
    logic [STATE_W-1:0]     s_q, sn_q;
    logic [ACTION_W-1:0]    a_q;
    logic signed [Q_W-1:0]  r_q, maxq_q, q_new_q;
    logic                   term_q, ready_q, done_q;

    logic                   we_a;
    logic [ADDR_W-1:0]      addr_a;
    logic [Q_W-1:0]         wdata_a;
    logic signed [Q_W-1:0]  rdata_a;

    logic signed [19:0]     maxq_w, r_w, qsa_w, fut_w, target_w, delta_w, sum_w;
    logic signed [27:0]     prod_w;
    logic signed [Q_W-1:0]  q_calc;

    q_table_ram u_ram (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_a_i    (we_a),
        .addr_a_i  (addr_a),
        .wdata_a_i (wdata_a),
        .rdata_a_o (rdata_a),
        .addr_b_i  ({bus.qry_state, bus.qry_action}),
        .rdata_b_o (bus.qry_q)
    );

    // cnt 0..3 walks the four actions of s', cnt 4 fetches Q(s,a).
    always_comb begin
        we_a    = 1'b0;
        addr_a  = {sn_q, cnt_q[1:0]};
        wdata_a = q_new_q;
        case (state_q)
            ST_INIT: begin we_a = 1'b1; addr_a = cnt_q; wdata_a = '0; end
            ST_RD:   if (cnt_q == ADDR_W'(4)) addr_a = {s_q, a_q};
            ST_WR:   begin we_a = 1'b1; addr_a = {s_q, a_q}; end
            default: ;
        endcase
    end

    always_comb begin
        maxq_w   = term_q ? 20'sd0 : 20'(maxq_q);
        prod_w   = 28'(GAMMA) * 28'(maxq_w);
        fut_w    = 20'(prod_w >>> 8);
        r_w      = 20'(r_q);
        qsa_w    = 20'(rdata_a);
        target_w = r_w + fut_w;
        delta_w  = target_w - qsa_w;
        sum_w    = qsa_w + (delta_w >>> ALPHA_SHIFT);
        q_calc   = sat_q(sum_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            s_q     <= '0;
            a_q     <= '0;
            sn_q    <= '0;
            r_q     <= '0;
            term_q  <= 1'b0;
            maxq_q  <= '0;
            q_new_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: if (bus.start) begin
                    s_q     <= bus.cur_state;
                    a_q     <= bus.action;
                    sn_q    <= bus.next_state;
                    r_q     <= bus.reward;
                    term_q  <= bus.terminal;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    state_q <= ST_RD;
                end
                ST_RD: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Read data lags the address by one cycle, so cnt 1..4 carries Q(s',cnt-1).
                    if (cnt_q != '0 && (cnt_q == ADDR_W'(1) || rdata_a > maxq_q))
                        maxq_q <= rdata_a;
                    if (cnt_q == ADDR_W'(4)) state_q <= ST_CALC;
                end
                ST_CALC: begin
                    q_new_q <= q_calc;
                    done_q  <= 1'b1;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.q_new = q_new_q;
endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit: default alpha instance plus an alpha=1 instance for saturation.
module tb_q_update_unit;
    import qlearn_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    q_update_unit_if bus0 ();
    q_update_unit_if bus1 ();

    q_update_unit #(.ALPHA_SHIFT(2), .GAMMA(230)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    q_update_unit #(.ALPHA_SHIFT(0), .GAMMA(230)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? bus0.ready : bus1.ready;
    endfunction
    function automatic logic dn(input int u);
        return (u == 0) ? bus0.done : bus1.done;
    endfunction
    function automatic logic signed [15:0] qn(input int u);
        return (u == 0) ? bus0.q_new : bus1.q_new;
    endfunction
    function automatic logic signed [15:0] qq(input int u);
        return (u == 0) ? bus0.qry_q : bus1.qry_q;
    endfunction

    task automatic set_start(input int u, input logic st);
        if (u == 0) bus0.start = st; else bus1.start = st;
    endtask

    task automatic drive(input int u, input logic st, input int s, input int a, input int sn,
                         input logic signed [15:0] r, input logic term);
        if (u == 0) begin
            bus0.start = st; bus0.cur_state = 6'(s); bus0.action = 2'(a);
            bus0.next_state = 6'(sn); bus0.reward = r; bus0.terminal = term;
            bus0.qry_state = 6'(s); bus0.qry_action = 2'(a);
        end else begin
            bus1.start = st; bus1.cur_state = 6'(s); bus1.action = 2'(a);
            bus1.next_state = 6'(sn); bus1.reward = r; bus1.terminal = term;
            bus1.qry_state = 6'(s); bus1.qry_action = 2'(a);
        end
    endtask

    // One full update: checks handshake, 7-cycle latency, q_new and the query read-back.
    task automatic upd(input int u, input int s, input int a, input int sn,
                       input logic signed [15:0] r, input logic term,
                       input logic signed [15:0] exp, input string tag);
        int k;
        int lat;
        logic signed [15:0] qv;
        k = 0;
        while (rdy(u) !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        chk({tag, "/ready_in"}, rdy(u), 1);
        drive(u, 1'b1, s, a, sn, r, term);
        @(posedge clk); #1;
        set_start(u, 1'b0);
        chk({tag, "/ready_drop"}, rdy(u), 0);
        lat = 0;
        k   = 1;
        qv  = 'x;
        while (lat == 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (dn(u) === 1'b1) begin lat = k; qv = qn(u); end
        end
        chk({tag, "/latency"}, lat, 7);
        chk({tag, "/q_new"}, qv, exp);
        @(posedge clk); #1;
        chk({tag, "/ready_back"}, rdy(u), 1);
        chk({tag, "/done_pulse"}, dn(u), 0);
        chk({tag, "/qry"}, qq(u), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_done;
        rst_n = 1'b0;
        drive(0, 1'b0, 0, 0, 0, 16'sd0, 1'b0);
        drive(1, 1'b0, 0, 0, 0, 16'sd0, 1'b0);
        #1;
        chk("rst/ready", bus0.ready, 0);
        chk("rst/done", bus0.done, 0);
        chk("rst/q_new", bus0.q_new, 0);
        chk("rst/qry_q", bus0.qry_q, 0);

        // Test 1: INIT length and table cleared
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus0.ready !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk("init/cycles", n, 256);
        chk("init/ready1", bus1.ready, 1);
        for (int i = 0; i < 256; i++) begin
            bus0.qry_state  = i[7:2];
            bus0.qry_action = i[1:0];
            @(posedge clk); #1;
            chk("init/qry_zero", bus0.qry_q, 0);
        end

        // Test 2: goal reward accumulates
        upd(0, 24, 1, 25, 16'sd100, 1'b1, 16'sd25, "t2a");
        upd(0, 24, 1, 25, 16'sd100, 1'b1, 16'sd43, "t2b");
        upd(0, 24, 1, 25, 16'sd100, 1'b1, 16'sd57, "t2c");
        upd(0, 24, 1, 25, 16'sd100, 1'b1, 16'sd67, "t2d");

        // Test 3: discounted future term
        upd(0, 23, 1, 24, 16'sd0, 1'b0, 16'sd15, "t3");

        // Test 4: negative reward, floor shift
        upd(0, 2, 1, 3, -16'sd100, 1'b1, -16'sd25, "t4a");
        upd(0, 2, 1, 3, -16'sd100, 1'b1, -16'sd44, "t4b");

        // Wall bounce: s == s' uses the pre-update value (maxq=25 -> 24)
        upd(0, 5, 2, 5, 16'sd100, 1'b1, 16'sd25, "wall_a");
        upd(0, 5, 2, 5, 16'sd0, 1'b0, 16'sd24, "wall_b");

        // Test 5: alpha=1 instance, saturation both ways
        for (int a = 0; a < 4; a++)
            upd(1, 11, a, 0, 16'sd32767, 1'b1, 16'sd32767, "t5_pre11");
        upd(1, 10, 0, 0, 16'sd32767, 1'b1, 16'sd32767, "t5_pre10");
        upd(1, 10, 0, 11, 16'sd32767, 1'b0, 16'sd32767, "t5_satpos");
        upd(1, 10, 0, 11, -16'sd32768, 1'b1, -16'sd32768, "t5_neg");
        upd(1, 10, 0, 11, -16'sd32768, 1'b1, -16'sd32768, "t5_hold");
        upd(1, 10, 0, 11, -16'sd32768, 1'b0, -16'sd3329, "t5_mix");

        // Test 6: reset mid-update aborts the write, start ignored during INIT
        n = 0;
        while (bus0.ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        drive(0, 1'b1, 24, 1, 25, 16'sd100, 1'b1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6/rst_done", bus0.done, 0);
        chk("t6/rst_ready", bus0.ready, 0);
        chk("t6/rst_qnew", bus0.q_new, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        seen_done = 1'b0;
        while (bus0.ready !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (bus0.done === 1'b1) seen_done = 1'b1;
        end
        bus0.start = 1'b0;
        chk("t6/init_cycles", n, 256);
        chk("t6/no_done", seen_done, 0);
        bus0.qry_state = 6'd24; bus0.qry_action = 2'd1;
        @(posedge clk); #1;
        chk("t6/qry_24_1", bus0.qry_q, 0);
        bus0.qry_state = 6'd23; bus0.qry_action = 2'd1;
        @(posedge clk); #1;
        chk("t6/qry_23_1", bus0.qry_q, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6/idle_no_done", bus0.done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
